// File: rtl/mem_dp48.sv
// mem_dp48 - dual-port, word-addressed 24-bit data memory for the MA/MO
// memory-stage pair.
//
// Each port has a registered address phase and a data phase. In the address
// phase the address is latched into r_addr_q[p]. In the data phase a 24-bit
// or packed 48-bit little-endian word pair is read (combinationally) or
// written (on the rising edge) at that address. A 48-bit access covers words
// a and a+1, and a+1 wraps modulo the depth.
//
// Handshake: there is no backpressure. iw_mem_addr_vld[p] is a one-cycle
// strobe that loads the address on the edge where it is high.
// iw_mem_we[p] commits a write on the edge that ends the data-phase cycle.
// Every phase completes in exactly one cycle.
//
// Parameters:
//   DEPTH_LOG2  log2 of the number of 24-bit words (default 12)
//   HBIT_ADDR   top bit of the address bus (default 47, so the bus is 48 bits)
//
// Ports ([0:1] = per-port unpacked array):
//   iw_clk                   clock
//   iw_rst                   synchronous active-high reset
//   iw_mem_addr_vld[0:1]     address phase strobe
//   iw_mem_addr[0:1]         word address (low DEPTH_LOG2 bits used)
//   iw_mem_we[0:1]           data phase write enable
//   iw_mem_wdata[0:1]        write data ([23:0] only for 24-bit accesses)
//   iw_mem_is48[0:1]         access width: 1 = 48-bit, 0 = 24-bit
//   ow_mem_rdata[0:1]        combinational read data
//   ow_mem_collide           sticky same-word write collision flag
//                            (only when MEM_COLLIDE_CHK_EN is defined)
//
// Optional feature macro: MEM_COLLIDE_CHK_EN.
//
// The storage array has no reset. Its contents rely on the zero power-up
// state of the RAM and are kept through iw_rst.
module mem_dp48 #(
  parameter int DEPTH_LOG2 = 12,
  parameter int HBIT_ADDR  = 47
) (
  input  logic                 iw_clk,
  input  logic                 iw_rst,
  input  logic                 iw_mem_addr_vld [0:1],
  input  logic [HBIT_ADDR:0]   iw_mem_addr     [0:1],
  input  logic                 iw_mem_we       [0:1],
  input  logic [47:0]          iw_mem_wdata    [0:1],
  input  logic                 iw_mem_is48     [0:1],
  output logic [47:0]          ow_mem_rdata    [0:1]
`ifdef MEM_COLLIDE_CHK_EN
  ,
  output logic                 ow_mem_collide
`endif
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2-1:0] ONE = DEPTH_LOG2'(1);

  logic [DEPTH_LOG2-1:0] r_addr_q [0:1];
  logic [DEPTH_LOG2-1:0] r_addr_d [0:1];

  // Write indices always come from the currently latched address. That way a
  // same-edge address strobe only affects the next data phase.
  logic [DEPTH_LOG2-1:0] wr_a  [0:1];
  logic [DEPTH_LOG2-1:0] wr_a1 [0:1];

  // The read index is forced to 0 while reset is high. This makes the read
  // port show address 0 during reset, not only after the reset edge.
  logic [DEPTH_LOG2-1:0] rd_a  [0:1];
  logic [DEPTH_LOG2-1:0] rd_a1 [0:1];

  logic [23:0] mem_q [0:DEPTH-1];

  // Upper address bits are ignored by design.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{iw_mem_addr[0][HBIT_ADDR:DEPTH_LOG2],
                              iw_mem_addr[1][HBIT_ADDR:DEPTH_LOG2]};

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      r_addr_d[p] = iw_mem_addr_vld[p] ? iw_mem_addr[p][DEPTH_LOG2-1:0]
                                       : r_addr_q[p];
      wr_a[p]  = r_addr_q[p];
      wr_a1[p] = r_addr_q[p] + ONE;
      rd_a[p]  = iw_rst ? '0 : r_addr_q[p];
      rd_a1[p] = rd_a[p] + ONE;
      if (iw_mem_is48[p]) begin
        ow_mem_rdata[p] = {mem_q[rd_a1[p]], mem_q[rd_a[p]]};
      end else begin
        ow_mem_rdata[p] = {24'b0, mem_q[rd_a[p]]};
      end
    end
  end

  always_ff @(posedge iw_clk) begin
    if (iw_rst) begin
      r_addr_q[0] <= '0;
      r_addr_q[1] <= '0;
    end else begin
      r_addr_q[0] <= r_addr_d[0];
      r_addr_q[1] <= r_addr_d[1];
    end
  end

  // Port 0 is written first and port 1 second. When both ports write the same
  // word, the later non-blocking assignment (port 1) wins, word by word. Words
  // that do not overlap are written by their own port.
  always_ff @(posedge iw_clk) begin
    if (!iw_rst) begin
      for (int p = 0; p < 2; p++) begin
        if (iw_mem_we[p]) begin
          mem_q[wr_a[p]] <= iw_mem_wdata[p][23:0];
          if (iw_mem_is48[p]) begin
            mem_q[wr_a1[p]] <= iw_mem_wdata[p][47:24];
          end
        end
      end
    end
  end

`ifdef MEM_COLLIDE_CHK_EN
  logic collide_q;
  logic collide_d;
  logic overlap_w;

  // Only words that are actually written take part in the overlap test.
  // The a+1 word counts only for a 48-bit access.
  always_comb begin
    overlap_w = (wr_a[0] == wr_a[1])
             || (iw_mem_is48[0] && (wr_a1[0] == wr_a[1]))
             || (iw_mem_is48[1] && (wr_a[0] == wr_a1[1]))
             || (iw_mem_is48[0] && iw_mem_is48[1] && (wr_a1[0] == wr_a1[1]));
    collide_d = collide_q | (iw_mem_we[0] & iw_mem_we[1] & overlap_w);
  end

  always_ff @(posedge iw_clk) begin
    if (iw_rst) begin
      collide_q <= 1'b0;
    end else begin
      collide_q <= collide_d;
    end
  end

  assign ow_mem_collide = collide_q;
`endif

endmodule

// File: tb/tb_mem_dp48.sv
// Testbench for mem_dp48.
// Structure: clock/reset, driver tasks, scoreboard with expected queue, final report.
module tb_mem_dp48;

  localparam int AW = 12;

  logic        clk;
  logic        rst;
  logic        vld    [0:1];
  logic [47:0] addr   [0:1];
  logic        we     [0:1];
  logic [47:0] wdata  [0:1];
  logic        is48   [0:1];
  logic [47:0] rdata  [0:1];
`ifdef MEM_COLLIDE_CHK_EN
  logic        collide;
`endif

  mem_dp48 #(.DEPTH_LOG2(AW), .HBIT_ADDR(47)) dut (
    .iw_clk          (clk),
    .iw_rst          (rst),
    .iw_mem_addr_vld (vld),
    .iw_mem_addr     (addr),
    .iw_mem_we       (we),
    .iw_mem_wdata    (wdata),
    .iw_mem_is48     (is48),
    .ow_mem_rdata    (rdata)
`ifdef MEM_COLLIDE_CHK_EN
    ,
    .ow_mem_collide  (collide)
`endif
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- reference model + scoreboard ----------------
  logic [23:0]   m_mem  [0:(1<<AW)-1];
  logic [AW-1:0] m_addr [0:1];
  logic          m_col;
  logic [47:0]   exp_q[$];
  int            checks;
  int            errors;

  task automatic check_eq(input string tag, input logic [47:0] got, input logic [47:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_addr(input int p, input logic [AW-1:0] a);
    vld[p]  = 1'b1;
    addr[p] = {{(48-AW){1'b0}}, a};
  endtask

  task automatic set_wr(input int p, input logic w48, input logic [47:0] d);
    we[p]    = 1'b1;
    is48[p]  = w48;
    wdata[p] = d;
  endtask

  // Advance one clock. The model commits this edge's effects.
  // Strobes are released just after the edge.
  task automatic step();
    logic [AW-1:0] lo [0:1];
    logic [AW-1:0] hi [0:1];
    @(posedge clk);
    if (rst) begin
      m_addr[0] = '0;
      m_addr[1] = '0;
      m_col     = 1'b0;
    end else begin
      for (int p = 0; p < 2; p++) begin
        lo[p] = m_addr[p];
        hi[p] = m_addr[p] + AW'(1);
      end
      if (we[0] && we[1]) begin
        if ((lo[0] == lo[1]) || (is48[0] && hi[0] == lo[1]) ||
            (is48[1] && lo[0] == hi[1]) || (is48[0] && is48[1] && hi[0] == hi[1]))
          m_col = 1'b1;
      end
      for (int p = 0; p < 2; p++) begin
        if (we[p]) begin
          m_mem[lo[p]] = wdata[p][23:0];
          if (is48[p]) m_mem[hi[p]] = wdata[p][47:24];
        end
      end
      for (int p = 0; p < 2; p++)
        if (vld[p]) m_addr[p] = addr[p][AW-1:0];
    end
    #1;
    vld[0] = 1'b0; vld[1] = 1'b0;
    we[0]  = 1'b0; we[1]  = 1'b0;
  endtask

  // Push the expected read, let the combinational path settle, pop and compare.
  task automatic rd_expect(input int p, input string tag, input logic [47:0] exp);
    logic [47:0] e;
    exp_q.push_back(exp);
    #1;
    e = exp_q.pop_front();
    check_eq(tag, rdata[p], e);
  endtask

  task automatic rd_model(input int p, input string tag);
    logic [AW-1:0] a;
    logic [AW-1:0] a1;
    a  = rst ? '0 : m_addr[p];
    a1 = a + AW'(1);
    rd_expect(p, tag, is48[p] ? {m_mem[a1], m_mem[a]} : {24'd0, m_mem[a]});
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] r0;
    logic [31:0] r1;
    checks = 0;
    errors = 0;
    for (int i = 0; i < (1 << AW); i++) m_mem[i] = '0;
    m_addr[0] = '0; m_addr[1] = '0; m_col = 1'b0;
    rst = 1'b1;
    for (int p = 0; p < 2; p++) begin
      vld[p] = 1'b0; addr[p] = '0; we[p] = 1'b0; wdata[p] = '0; is48[p] = 1'b0;
    end
    step();
    step();
    rst = 1'b0;
`ifdef MEM_COLLIDE_CHK_EN
    check_eq("reset_collide", {47'd0, collide}, 48'd0);
`endif

    // 24-bit write on port 0, read back through port 1
    set_addr(0, 12'h010); step();
    set_wr(0, 1'b0, 48'h0000_00AB_CDEF); set_addr(1, 12'h010); step();
    is48[1] = 1'b0;
    rd_expect(1, "t1_p1_rd24", 48'h0000_00AB_CDEF);

    // 48-bit write on port 1, little-endian layout
    set_addr(1, 12'h020); step();
    set_wr(1, 1'b1, 48'h123456_789ABC); set_addr(0, 12'h020); step();
    is48[0] = 1'b1;
    rd_expect(0, "t2_p0_rd48", 48'h123456_789ABC);
    is48[0] = 1'b0;
    rd_expect(0, "t2_lo_word", 48'h000000_789ABC);
    set_addr(0, 12'h021); step();
    rd_expect(0, "t2_hi_word", 48'h000000_123456);

    // 48-bit access at the top address wraps to word 0
    set_addr(0, 12'hFFF); step();
    set_wr(0, 1'b1, 48'h111111_222222); step();
    is48[0] = 1'b1;
    rd_expect(0, "t3_rd48_wrap", 48'h111111_222222);
    is48[0] = 1'b0;
    rd_expect(0, "t3_lo_fff", 48'h000000_222222);
    set_addr(1, 12'h000); step();
    is48[1] = 1'b0;
    rd_expect(1, "t3_word0", 48'h000000_111111);

    // same-word collision: port 1 wins
    set_addr(0, 12'h040); set_addr(1, 12'h040); step();
    set_wr(0, 1'b0, 48'h000001); set_wr(1, 1'b0, 48'h000002); step();
    rd_expect(0, "t4_p1_wins_p0", 48'h000002);
    rd_expect(1, "t4_p1_wins_p1", 48'h000002);
`ifdef MEM_COLLIDE_CHK_EN
    check_eq("t4_collide", {47'd0, collide}, 48'd1);
`endif

    // partial overlap: only word 0x61 is shared
    set_addr(0, 12'h060); set_addr(1, 12'h061); step();
    set_wr(0, 1'b1, 48'hA1A1A1_A0A0A0); set_wr(1, 1'b1, 48'hB1B1B1_B0B0B0); step();
    rd_expect(0, "t4_partial_p0", 48'hB0B0B0_A0A0A0);
    rd_expect(1, "t4_partial_p1", 48'hB1B1B1_B0B0B0);

    // write plus address strobe on the same edge
    set_addr(0, 12'h050); step();
    set_wr(0, 1'b0, 48'h5A5A5A); step();
    set_addr(0, 12'h070); step();
    set_wr(0, 1'b0, 48'hAAAAAA); set_addr(0, 12'h050); step();
    rd_expect(0, "t5_new_addr_read", 48'h5A5A5A);
    set_addr(1, 12'h070); step();
    is48[1] = 1'b0;
    rd_expect(1, "t5_write_old_addr", 48'hAAAAAA);

    // reset during a write
    set_addr(0, 12'h080); step();
    set_wr(0, 1'b0, 48'h777777); step();
    set_addr(1, 12'h020); step();
    rst = 1'b1;
    set_wr(0, 1'b0, 48'h555555);
    is48[1] = 1'b0;
    rd_expect(0, "t6_in_rst_p0", 48'h111111);
    rd_expect(1, "t6_in_rst_p1", 48'h111111);
    step();
    rst = 1'b0;
    rd_expect(0, "t6_addr0_p0", 48'h111111);
    rd_expect(1, "t6_addr0_p1", 48'h111111);
`ifdef MEM_COLLIDE_CHK_EN
    check_eq("t6_collide_clr", {47'd0, collide}, 48'd0);
`endif
    set_addr(0, 12'h080); set_addr(1, 12'h020); step();
    is48[1] = 1'b1;
    rd_expect(0, "t6_write_dropped", 48'h777777);
    rd_expect(1, "t6_retained", 48'h123456_789ABC);

    // randomized traffic over a small, pre-written window
    for (int i = 0; i < 8; i++) begin
      set_addr(0, AW'(12'h100 + 2 * i)); step();
      r0 = $urandom; r1 = $urandom;
      set_wr(0, 1'b1, {r1[23:0], r0[23:0]}); step();
    end
    for (int i = 0; i < 30; i++) begin
      for (int p = 0; p < 2; p++)
        set_addr(p, AW'($urandom_range(12'h100, 12'h10E)));
      step();
      for (int p = 0; p < 2; p++) begin
        r0 = $urandom; r1 = $urandom;
        if ($urandom_range(0, 1) == 1)
          set_wr(p, 1'($urandom_range(0, 1)), {r1[23:0], r0[23:0]});
      end
      step();
      for (int p = 0; p < 2; p++) begin
        is48[p] = 1'($urandom_range(0, 1));
        rd_model(p, $sformatf("rand_%0d_p%0d", i, p));
      end
`ifdef MEM_COLLIDE_CHK_EN
      check_eq("rand_collide", {47'd0, collide}, {47'd0, m_col});
`endif
    end

    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
